// File: rtl/tbird_monitor.sv
// Passive checker/decoder for the Thunderbird tail-light bus.
// Samples TLIGHT once, then tracks the lamp sequence, reports the recognised
// mode, counts completed flash cycles and flags illegal lamp transitions.
// Outputs lag the bus by two clock edges and are all registered.
module tbird_monitor #(
  parameter int HOLD_MAX    = 1,   // 1..15 consecutive samples of one non-zero pattern
  parameter int IDLE_CYCLES = 4    // 1..255 consecutive all-off samples to declare IDLE
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] TLIGHT,
  output logic [2:0] MODE,
  output logic       ERR,
  output logic [7:0] CYCLES,
  output logic [7:0] ERR_CNT
);

  typedef enum logic [3:0] {
    TZ, TL1, TL2, TL3, TR1, TR2, TR3, TH, TUNK
  } trk_e;

  typedef enum logic [2:0] {
    MODE_IDLE    = 3'd0,
    MODE_LEFT    = 3'd1,
    MODE_RIGHT   = 3'd2,
    MODE_HAZARD  = 3'd3,
    MODE_UNKNOWN = 3'd4
  } mode_e;

  localparam logic [3:0] HOLD_LIMIT = 4'(HOLD_MAX);
  localparam logic [7:0] IDLE_LIMIT = 8'(IDLE_CYCLES);

  logic [5:0] tl_d, tl_q;
  trk_e       trk_d, trk_q;
  logic [3:0] hold_d, hold_q;
  logic [7:0] idle_d, idle_q;
  mode_e      mode_d, mode_q;
  logic       err_d, err_q;
  logic [7:0] cyc_d, cyc_q;
  logic [7:0] ecnt_d, ecnt_q;

  // Pattern decode of the registered bus sample.
  logic pat_legal;
  trk_e pat_state;
  logic is_z;

  // Lamp bits [7:6] carry nothing of interest and are dropped at the input.
  assign tl_d = TLIGHT[5:0];
  assign is_z = (tl_q == 6'h00);

  // Map the sampled lamp pattern to the tracker state it represents.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    pat_legal = 1'b1;
    pat_state = TUNK;
    case (tl_q)
      6'h00:   pat_state = TZ;
      6'h08:   pat_state = TL1;
      6'h18:   pat_state = TL2;
      6'h38:   pat_state = TL3;
      6'h01:   pat_state = TR1;
      6'h03:   pat_state = TR2;
      6'h07:   pat_state = TR3;
      6'h3F:   pat_state = TH;
      default: pat_legal = 1'b0;
    endcase
  end

  // Transition legality, completion detection and next-state of all counters.
  logic  bad;
  logic  is_repeat;
  logic  step_ok;
  logic  comp;
  mode_e comp_mode;

  always_comb begin
    trk_d     = trk_q;
    hold_d    = hold_q;
    mode_d    = mode_q;
    cyc_d     = cyc_q;
    ecnt_d    = ecnt_q;
    err_d     = 1'b0;
    bad       = 1'b0;
    comp      = 1'b0;
    comp_mode = MODE_IDLE;
    is_repeat = 1'b0;
    step_ok   = 1'b0;

    // Consecutive all-off samples, saturating so a long idle never wraps.
    if (is_z) idle_d = (idle_q == 8'hFF) ? idle_q : idle_q + 8'd1;
    else      idle_d = 8'd0;

    if (trk_q == TUNK) begin
      // Lost sync: wait silently for all lamps off, then resynchronise.
      if (is_z) begin
        trk_d  = TZ;
        hold_d = 4'd1;
      end
    end else begin
      is_repeat = pat_legal && (pat_state == trk_q);
      case (trk_q)
        TZ:      step_ok = (pat_state == TL1) || (pat_state == TR1) || (pat_state == TH);
        TL1:     step_ok = (pat_state == TL2);
        TL2:     step_ok = (pat_state == TL3);
        TR1:     step_ok = (pat_state == TR2);
        TR2:     step_ok = (pat_state == TR3);
        default: step_ok = 1'b0;
      endcase

      if (!pat_legal)     bad = 1'b1;
      else if (is_repeat) bad = !is_z && (hold_q >= HOLD_LIMIT);
      else                bad = !is_z && !step_ok;

      if (!bad) begin
        trk_d  = pat_state;
        hold_d = !is_repeat ? 4'd1 : (hold_q == 4'hF) ? hold_q : hold_q + 4'd1;
        // TL3/TR3 are reachable only through the full chain from TZ, so
        // reaching Z from them already implies a complete flash cycle.
        if (is_z) begin
          case (trk_q)
            TL3: begin comp = 1'b1; comp_mode = MODE_LEFT;   end
            TR3: begin comp = 1'b1; comp_mode = MODE_RIGHT;  end
            TH:  begin comp = 1'b1; comp_mode = MODE_HAZARD; end
            default: ;
          endcase
        end
      end
    end

    // Output update, highest priority first: error, completion, idle.
    if (bad) begin
      trk_d  = TUNK;
      hold_d = 4'd0;
      err_d  = 1'b1;
      ecnt_d = (ecnt_q == 8'hFF) ? ecnt_q : ecnt_q + 8'd1;
      mode_d = MODE_UNKNOWN;
      cyc_d  = 8'd0;
    end else if (comp) begin
      if (mode_q == comp_mode) begin
        cyc_d = (cyc_q == 8'hFF) ? cyc_q : cyc_q + 8'd1;
      end else begin
        mode_d = comp_mode;
        cyc_d  = 8'd1;
      end
    end else if ((idle_d == IDLE_LIMIT) && (mode_q != MODE_IDLE)) begin
      mode_d = MODE_IDLE;
      cyc_d  = 8'd0;
    end
  end

  // Input sample register plus all tracker, counter and output state.
  always_ff @(posedge CLK) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // sees the pre-edge value of the others, independent of statement order.
    if (RST) begin
      tl_q   <= 6'h00;
      trk_q  <= TZ;
      hold_q <= 4'd0;
      idle_q <= 8'd0;
      mode_q <= MODE_IDLE;
      err_q  <= 1'b0;
      cyc_q  <= 8'd0;
      ecnt_q <= 8'd0;
    end else begin
      tl_q   <= tl_d;
      trk_q  <= trk_d;
      hold_q <= hold_d;
      idle_q <= idle_d;
      mode_q <= mode_d;
      err_q  <= err_d;
      cyc_q  <= cyc_d;
      ecnt_q <= ecnt_d;
    end
  end

  assign MODE    = mode_q;
  assign ERR     = err_q;
  assign CYCLES  = cyc_q;
  assign ERR_CNT = ecnt_q;

endmodule
